// File: rtl/rs_alloc_ctrl_pkg.sv
// Shared types and default sizing for the reservation-station allocation controller.
package rs_alloc_ctrl_pkg;

  localparam int RS_SZ = 16;
  localparam int N     = 2;

  typedef logic [$clog2(RS_SZ)-1:0]   RS_IDX;
  typedef logic [$clog2(RS_SZ+1)-1:0] RS_CNT;

endpackage

// File: rtl/rs_alloc_ctrl_slot_pick.sv
// Multi-way priority encoder: returns up to WAYS lowest-indexed set bits of i_free,
// both as one-hot vectors and as encoded indices.
module rs_slot_pick
  import rs_alloc_ctrl_pkg::*;
#(
  parameter  int SIZE  = RS_SZ,
  parameter  int WAYS  = N,
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]                i_free,
  output logic [WAYS-1:0]                o_found,
  output logic [WAYS-1:0][SIZE-1:0]      o_onehot,
  output logic [WAYS-1:0][IDX_W-1:0]     o_idx
);

  // Each way takes the lowest remaining bit, then removes it for the next way.
  always_comb begin
    logic [SIZE-1:0] w_remain;
    w_remain = i_free;
    o_found  = '0;
    o_onehot = '0;
    o_idx    = '0;
    for (int j = 0; j < WAYS; j++) begin
      for (int i = SIZE - 1; i >= 0; i--) begin
        if (w_remain[i]) begin
          o_onehot[j]    = '0;
          o_onehot[j][i] = 1'b1;
          o_idx[j]       = IDX_W'(i);
          o_found[j]     = 1'b1;
        end
      end
      w_remain = w_remain & ~o_onehot[j];
    end
  end

endmodule

// File: rtl/rs_alloc_ctrl.sv
// Reservation-station slot allocator: owns the occupancy bitmap, grants free entries
// to dispatch, reclaims issued entries and flushes everything on squash.
module rs_alloc_ctrl
  import rs_alloc_ctrl_pkg::*;
#(
  parameter  int SIZE        = RS_SZ,
  parameter  int DISPATCH_W  = N,
  parameter  int ALERT_DEPTH = N,
  localparam int IDX_W       = $clog2(SIZE),
  localparam int CNT_W       = $clog2(SIZE + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DISPATCH_W-1:0]             alloc_req,
  output logic [DISPATCH_W-1:0]             alloc_gnt,
  output logic [DISPATCH_W-1:0][IDX_W-1:0]  alloc_idx,
  input  logic [SIZE-1:0]                   free_mask,
  input  logic                              squash,
  output logic [SIZE-1:0]                   entry_valid,
  output logic [CNT_W-1:0]                  count,
  output logic [CNT_W-1:0]                  free_slots,
  output logic                              almost_full,
  output logic                              error
);

  logic [SIZE-1:0]                  r_valid;
  logic [CNT_W-1:0]                 r_count;
  logic                             r_error;

  logic [DISPATCH_W-1:0]            w_run;
  logic [DISPATCH_W-1:0]            w_found;
  logic [DISPATCH_W-1:0][SIZE-1:0]  w_onehot;
  logic [DISPATCH_W-1:0]            w_gnt;
  logic [SIZE-1:0]                  w_allocMask;
  logic [SIZE-1:0]                  w_rel;
  logic [SIZE-1:0]                  w_badFree;
  logic [CNT_W-1:0]                 w_countNext;

  rs_slot_pick #(
    .SIZE (SIZE),
    .WAYS (DISPATCH_W)
  ) u_pick (
    .i_free   (~r_valid),
    .o_found  (w_found),
    .o_onehot (w_onehot),
    .o_idx    (alloc_idx)
  );

  // Only the unbroken run of requests starting at slot 0 is honoured.
  always_comb begin
    logic w_still;
    w_still = 1'b1;
    w_run   = '0;
    for (int j = 0; j < DISPATCH_W; j++) begin
      w_still  = w_still & alloc_req[j];
      w_run[j] = w_still;
    end
  end

  assign w_gnt     = w_run & w_found & {DISPATCH_W{reset & ~squash}};
  assign alloc_gnt = w_gnt;

  always_comb begin
    w_allocMask = '0;
    for (int j = 0; j < DISPATCH_W; j++) begin
      if (w_gnt[j]) begin
        w_allocMask = w_allocMask | w_onehot[j];
      end
    end
  end

  assign w_rel       = free_mask & r_valid;
  assign w_badFree   = free_mask & ~r_valid;
  assign w_countNext = r_count + CNT_W'($countones(w_gnt)) - CNT_W'($countones(w_rel));

  // Allocations and releases never touch the same entry, so they merge freely.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else if (squash) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= (r_valid | w_allocMask) & ~w_rel;
      r_count <= w_countNext;
      r_error <= r_error | (|w_badFree);
    end
  end

  assign entry_valid = r_valid;
  assign count       = r_count;
  assign error       = r_error;
  assign free_slots  = CNT_W'(SIZE) - r_count;
  assign almost_full = (r_count > CNT_W'(SIZE - ALERT_DEPTH));

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Self-checking bench for rs_alloc_ctrl: directed vector table, mid-cycle reset
// sequence, then randomized traffic against an entry-list reference model.
module tb_rs_alloc_ctrl;
  import rs_alloc_ctrl_pkg::*;

  localparam int SZ = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       alloc_req = '0;
  logic [1:0]       alloc_gnt;
  logic [1:0][3:0]  alloc_idx;
  logic [SZ-1:0]    free_mask = '0;
  logic             squash = 1'b0;
  logic [SZ-1:0]    entry_valid;
  logic [4:0]       count;
  logic [4:0]       free_slots;
  logic             almost_full;
  logic             error;

  int total = 0;
  int bad   = 0;

  bit occ [SZ];
  bit mErr;

  typedef struct {
    logic [1:0]    req;
    logic [SZ-1:0] fmask;
    logic          sq;
    logic [1:0]    eGnt;
    logic [3:0]    eIdx0;
    logic [3:0]    eIdx1;
    logic [SZ-1:0] eValid;
    logic [4:0]    eCount;
    logic          eErr;
  } vec_t;

  vec_t vq[$];

  rs_alloc_ctrl #(
    .SIZE        (16),
    .DISPATCH_W  (2),
    .ALERT_DEPTH (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_idx   (alloc_idx),
    .free_mask   (free_mask),
    .squash      (squash),
    .entry_valid (entry_valid),
    .count       (count),
    .free_slots  (free_slots),
    .almost_full (almost_full),
    .error       (error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [1:0] req, input logic [SZ-1:0] fm, input logic sq,
                        input logic [1:0] g, input int i0, input int i1,
                        input logic [SZ-1:0] v, input int c, input logic e);
    vec_t t;
    t.req = req; t.fmask = fm; t.sq = sq; t.eGnt = g;
    t.eIdx0 = 4'(i0); t.eIdx1 = 4'(i1); t.eValid = v; t.eCount = 5'(c); t.eErr = e;
    vq.push_back(t);
  endtask

  function automatic logic [SZ-1:0] modelVec();
    logic [SZ-1:0] v;
    v = '0;
    for (int e = 0; e < SZ; e++) v[e] = occ[e];
    return v;
  endfunction

  function automatic int modelCount();
    int c;
    c = 0;
    for (int e = 0; e < SZ; e++) c += int'(occ[e]);
    return c;
  endfunction

  task automatic modelClear(input bit clrErr);
    for (int e = 0; e < SZ; e++) occ[e] = 1'b0;
    if (clrErr) mErr = 1'b0;
  endtask

  // Reference: requests honoured = leading run of ones, handed the lowest free entries in order.
  task automatic modelGrant(input logic [1:0] req, input logic sq,
                            output logic [1:0] g, output int i0, output int i1);
    int k;
    int n;
    int freeQ[$];
    k = 0;
    g = '0; i0 = 0; i1 = 0;
    while (k < 2 && req[k]) k++;
    for (int e = 0; e < SZ; e++) if (!occ[e]) freeQ.push_back(e);
    n = (k < freeQ.size()) ? k : freeQ.size();
    if (sq) n = 0;
    if (n > 0) begin g[0] = 1'b1; i0 = freeQ[0]; end
    if (n > 1) begin g[1] = 1'b1; i1 = freeQ[1]; end
  endtask

  task automatic modelEdge(input logic [SZ-1:0] fm, input logic sq,
                           input logic [1:0] g, input int i0, input int i1);
    if (sq) begin
      modelClear(1'b0);
    end else begin
      for (int e = 0; e < SZ; e++) begin
        if (fm[e]) begin
          if (occ[e]) occ[e] = 1'b0;
          else mErr = 1'b1;
        end
      end
      if (g[0]) occ[i0] = 1'b1;
      if (g[1]) occ[i1] = 1'b1;
    end
  endtask

  // Called just after a rising edge: drive, check same-cycle grants, clock, check state.
  task automatic applyStimulus(input logic [1:0] req, input logic [SZ-1:0] fm, input logic sq);
    logic [1:0] g;
    int i0, i1, c;
    alloc_req = req; free_mask = fm; squash = sq;
    #2;
    modelGrant(req, sq, g, i0, i1);
    checkOutput("rnd_gnt", 32'(alloc_gnt), 32'(g));
    if (g[0]) checkOutput("rnd_idx0", 32'(alloc_idx[0]), 32'(i0));
    if (g[1]) checkOutput("rnd_idx1", 32'(alloc_idx[1]), 32'(i1));
    @(posedge clock);
    #1;
    modelEdge(fm, sq, g, i0, i1);
    c = modelCount();
    checkOutput("rnd_valid", 32'(entry_valid), 32'(modelVec()));
    checkOutput("rnd_count", 32'(count), 32'(c));
    checkOutput("rnd_free_slots", 32'(free_slots), 32'(SZ - c));
    checkOutput("rnd_almost_full", 32'(almost_full), 32'(c > SZ - 2));
    checkOutput("rnd_error", 32'(error), 32'(mErr));
    checkOutput("inv_count_pop", 32'(count), 32'($countones(entry_valid)));
  endtask

  task automatic doReset();
    alloc_req = 2'b11; free_mask = '0; squash = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_valid", 32'(entry_valid), 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_free_slots", 32'(free_slots), 32'd16);
    checkOutput("rst_almost_full", 32'(almost_full), 32'h0);
    checkOutput("rst_error", 32'(error), 32'h0);
    checkOutput("rst_gnt", 32'(alloc_gnt), 32'h0);
    reset = 1'b1;
    modelClear(1'b1);
  endtask

  initial begin
    logic [SZ-1:0] fm;
    modelClear(1'b1);

    // Directed table: fill, full, free-then-refill, squash, broken run, invalid free.
    for (int j = 0; j < 8; j++)
      addVec(2'b11, '0, 1'b0, 2'b11, 2*j, 2*j+1, SZ'((32'd1 << (2*j+2)) - 1), 2*j+2, 1'b0);
    addVec(2'b11, '0,       1'b0, 2'b00, 0, 0, 16'hFFFF, 16, 1'b0);
    addVec(2'b11, 16'h0001, 1'b0, 2'b00, 0, 0, 16'hFFFE, 15, 1'b0);
    addVec(2'b11, '0,       1'b0, 2'b01, 0, 0, 16'hFFFF, 16, 1'b0);
    addVec(2'b11, '0,       1'b1, 2'b00, 0, 0, 16'h0000, 0,  1'b0);
    addVec(2'b11, '0,       1'b0, 2'b11, 0, 1, 16'h0003, 2,  1'b0);
    addVec(2'b10, '0,       1'b0, 2'b00, 0, 0, 16'h0003, 2,  1'b0);
    addVec(2'b00, 16'h0004, 1'b0, 2'b00, 0, 0, 16'h0003, 2,  1'b1);
    addVec(2'b11, 16'h0003, 1'b0, 2'b11, 2, 3, 16'h000C, 2,  1'b1);
    addVec(2'b01, '0,       1'b0, 2'b01, 0, 0, 16'h000D, 3,  1'b1);
    addVec(2'b11, 16'h0F00, 1'b0, 2'b11, 1, 4, 16'h001F, 5,  1'b1);
    addVec(2'b11, 16'h8000, 1'b1, 2'b00, 0, 0, 16'h0000, 0,  1'b1);

    doReset();
    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      alloc_req = v.req; free_mask = v.fmask; squash = v.sq;
      #2;
      checkOutput($sformatf("vec%0d_gnt", i), 32'(alloc_gnt), 32'(v.eGnt));
      if (v.eGnt[0]) checkOutput($sformatf("vec%0d_idx0", i), 32'(alloc_idx[0]), 32'(v.eIdx0));
      if (v.eGnt[1]) checkOutput($sformatf("vec%0d_idx1", i), 32'(alloc_idx[1]), 32'(v.eIdx1));
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), 32'(entry_valid), 32'(v.eValid));
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(v.eCount));
      checkOutput($sformatf("vec%0d_free_slots", i), 32'(free_slots), 32'(16 - int'(v.eCount)));
      checkOutput($sformatf("vec%0d_almost_full", i), 32'(almost_full), 32'(v.eCount > 14));
      checkOutput($sformatf("vec%0d_error", i), 32'(error), 32'(v.eErr));
      checkOutput($sformatf("vec%0d_inv", i), 32'(count), 32'($countones(entry_valid)));
    end

    // Mid-cycle reset with nine entries held and error set: must clear without an edge.
    modelClear(1'b0);
    mErr = 1'b1;
    repeat (4) applyStimulus(2'b11, '0, 1'b0);
    applyStimulus(2'b01, '0, 1'b0);
    checkOutput("mid_pre_count", 32'(count), 32'd9);
    alloc_req = 2'b11; free_mask = '0; squash = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_valid", 32'(entry_valid), 32'h0);
    checkOutput("mid_count", 32'(count), 32'h0);
    checkOutput("mid_error", 32'(error), 32'h0);
    checkOutput("mid_gnt", 32'(alloc_gnt), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    modelClear(1'b1);
    alloc_req = 2'b01;
    #1;
    checkOutput("post_rst_gnt", 32'(alloc_gnt), 32'h1);
    checkOutput("post_rst_idx0", 32'(alloc_idx[0]), 32'h0);
    applyStimulus(2'b01, '0, 1'b0);

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) fm = SZ'($urandom);
      else fm = modelVec() & SZ'($urandom) & SZ'($urandom) & SZ'($urandom);
      applyStimulus(2'($urandom_range(0, 3)), fm, ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_alloc_ctrl.md
Name: rs_alloc_ctrl

Overview:
- Slot-allocation controller for the reservation station.
- Owns the RS occupancy bitmap and each cycle hands up to DISPATCH_W free entry indices to dispatch.
- Reclaims entries that issue has granted to functional units, and clears everything on squash.
- Provides occupancy count and almost_full backpressure to the dispatch stage.

Parameters:
- SIZE, `RS_SZ (16 in test config): number of RS entries.
- DISPATCH_W, `N (2 in test config): allocation requests per cycle.
- ALERT_DEPTH, `N: almost_full asserts when count > SIZE-ALERT_DEPTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- alloc_req  in  DISPATCH_W  per-dispatch-slot request; only a contiguous run from bit 0 is honoured.
- alloc_gnt  out  DISPATCH_W  grant per request slot, same cycle.
- alloc_idx  out  DISPATCH_W x $clog2(SIZE)  entry index per granted slot; don't-care when not granted.
- free_mask  in  SIZE  entries issued this cycle, to be released.
- squash  in  1  flush: release all entries.
- entry_valid  out  SIZE  registered occupancy bitmap.
- count  out  $clog2(SIZE+1)  registered number of valid entries.
- free_slots  out  $clog2(SIZE+1)  SIZE-count.
- almost_full  out  1  count > SIZE-ALERT_DEPTH.
- error  out  1  sticky flag: free of an invalid entry.

Behaviour:
- State: entry_valid[SIZE], count, error. Everything else is combinational from state and inputs.
- Reset (reset=0, async): entry_valid=0, count=0, error=0. Consequently free_slots=SIZE, almost_full=0. alloc_gnt is forced to 0 while reset=0.
- Effective request count k = number of consecutive 1s in alloc_req starting at bit 0. Example: 2'b10 gives k=0.
- Grant rule:
  - alloc_gnt[j]=1 for j < min(k, number of invalid entries in the registered bitmap).
  - alloc_idx[j] = j-th lowest-indexed invalid entry.
  - Partial grants are legal.
- Latency: grant and index are combinational in cycle t; the bitmap/count reflect the allocation after the edge ending cycle t.
- Release: free_mask bits clear entry_valid at the edge. Released entries are NOT allocatable in the same cycle; they become available from t+1.
- Simultaneous alloc and free: always on disjoint entries, since allocation only picks invalid entries and free only affects valid entries.
- count_next = count + popcount(alloc_gnt) - popcount(free_mask & entry_valid).
- Free of an invalid entry: that bit is ignored and error is set. error stays set until reset.
- Squash:
  - alloc_gnt forced 0 in that cycle.
  - Next state: entry_valid=0, count=0.
  - free_mask is ignored; error is unchanged.
- Full: no invalid entries, so alloc_gnt=0 regardless of request.
- Invariant (assert in bench): count == popcount(entry_valid) at every edge.

Decomposition:
- Shared package: RS_IDX typedef (logic [$clog2(`RS_SZ)-1:0]), RS_CNT typedef (logic [$clog2(`RS_SZ+1)-1:0]); `RS_SZ and `N come from sys_defs.
- One sub-module, rs_slot_pick:
  - Combinational multi-way priority encoder.
  - Input: ~entry_valid. Outputs: up to DISPATCH_W lowest-index one-hot grants plus encoded indices.
  - Instantiated once.

Test Plan (SIZE=16, DISPATCH_W=2, ALERT_DEPTH=2):
1. Release reset, alloc_req=2'b11 → alloc_gnt=2'b11, alloc_idx={1,0}. Next cycle entry_valid=16'h0003, count=2, free_slots=14.
2. Keep alloc_req=2'b11 for 8 cycles from reset → entry_valid=16'hFFFF, count=16, almost_full=1 (count passes 14 at that edge). Further alloc_req=2'b11 → alloc_gnt=2'b00.
3. Starting full, free_mask=16'h0001 with alloc_req=2'b11 → alloc_gnt=2'b00 that cycle. Next cycle entry_valid=16'hFFFE, count=15. Then alloc_req=2'b11 → alloc_gnt=2'b01, alloc_idx[0]=0; next cycle count=16.
4. entry_valid=16'h0003, alloc_req=2'b10 → alloc_gnt=2'b00. Then free_mask=16'h0004 → count stays 2, error=1, and error remains 1 for the rest of the test.
5. entry_valid=16'h00FF, squash=1 with alloc_req=2'b11 → alloc_gnt=2'b00. Next cycle entry_valid=0, count=0, free_slots=16, almost_full=0.
6. Assert reset=0 mid-cycle while count=9 → entry_valid, count and error clear immediately without a clock edge, and alloc_gnt=0. After release, alloc_req=2'b01 → alloc_idx[0]=0.
